// File: rtl/flash_job_sequencer.sv
// Job-level sequencer in front of a SPI flash command engine: expands RDID / ERASE /
// PROG / READ jobs over N units into engine commands, with status polling, timeout and abort.
module flash_job_sequencer #(
  parameter int ADDR_W       = 24,
  parameter int CNT_W        = 8,
  parameter int PAGE_BYTES   = 256,
  parameter int SECTOR_BYTES = 4096,
  parameter int GAP_CYCLES   = 100,
  parameter int POLL_MAX     = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [1:0]        job_op,
  input  logic [ADDR_W-1:0] job_addr,
  input  logic [CNT_W-1:0]  job_count,
  input  logic              job_abort,
  output logic              job_done,
  output logic [2:0]        err_code,
  output logic [3:0]        cmd_type,
  output logic [7:0]        flash_cmd,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              Done_Sig,
  input  logic [7:0]        mydata_o,
  output logic [7:0]        id_byte
);

  typedef enum logic [1:0] {OP_RDID = 2'b00, OP_ERASE = 2'b01, OP_PROG = 2'b10, OP_READ = 2'b11} op_e;
  typedef enum logic [3:0] {
    CMD_NONE = 4'h0, CMD_RDID = 4'h8, CMD_WREN = 4'h9, CMD_ERASE = 4'hA,
    CMD_RDSR = 4'hB, CMD_WRDI = 4'hC, CMD_PROG = 4'hD, CMD_READ = 4'hE
  } cmd_e;
  typedef enum logic [2:0] {
    ERR_OK = 3'b000, ERR_TIMEOUT = 3'b001, ERR_COUNT = 3'b010, ERR_RANGE = 3'b011, ERR_ABORT = 3'b100
  } err_e;
  typedef enum logic [3:0] {
    S_IDLE, S_RDID, S_WREN, S_GAP, S_EXEC, S_POLL, S_WRDI, S_POLL2, S_NEXT, S_DONE
  } state_e;

  // Wide enough that addr + count*stride can never overflow.
  localparam int EXT_W = ADDR_W + CNT_W + 14;

  function automatic logic [7:0] opcode_of(input cmd_e c);
    case (c)
      CMD_RDID:  opcode_of = 8'h90;
      CMD_WREN:  opcode_of = 8'h06;
      CMD_ERASE: opcode_of = 8'h20;
      CMD_RDSR:  opcode_of = 8'h05;
      CMD_WRDI:  opcode_of = 8'h04;
      CMD_PROG:  opcode_of = 8'h02;
      CMD_READ:  opcode_of = 8'h03;
      default:   opcode_of = 8'h00;
    endcase
  endfunction

  function automatic cmd_e exec_cmd(input op_e op);
    case (op)
      OP_ERASE: exec_cmd = CMD_ERASE;
      OP_PROG:  exec_cmd = CMD_PROG;
      default:  exec_cmd = CMD_READ;
    endcase
  endfunction

  state_e            r_state, w_state_nxt;
  op_e               r_op;
  cmd_e              r_cmd, w_issue_cmd;
  err_e              r_err, w_err_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt, r_flash_addr, w_stride;
  logic [CNT_W-1:0]  r_rem, w_rem_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic              r_timeout, w_timeout_nxt;
  logic [7:0]        r_flash_cmd, r_id_byte;
  logic              w_accept, w_issue, w_clear, w_id_load, w_active, w_range_bad, w_exec_issue;
  logic [EXT_W-1:0]  w_job_stride, w_job_end;

  assign w_active     = (r_cmd != CMD_NONE);
  assign w_cnt_inc    = r_cnt + 16'd1;
  assign w_stride     = (r_op == OP_ERASE) ? ADDR_W'(SECTOR_BYTES) : ADDR_W'(PAGE_BYTES);
  assign w_job_stride = (job_op == OP_ERASE) ? EXT_W'(SECTOR_BYTES) : EXT_W'(PAGE_BYTES);
  assign w_job_end    = EXT_W'(job_addr) + EXT_W'(job_count) * w_job_stride;
  assign w_range_bad  = (w_job_end > (EXT_W'(1) << ADDR_W));
  assign w_exec_issue = (w_issue_cmd == CMD_ERASE) || (w_issue_cmd == CMD_PROG) ||
                        (w_issue_cmd == CMD_READ);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    // NOTE: non-blocking so every register samples the pre-edge value of every other.
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal gets a default up front so no branch can leave a latch behind.
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_issue       = 1'b0;
    w_issue_cmd   = CMD_NONE;
    w_clear       = 1'b0;
    w_id_load     = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = r_addr;
    w_rem_nxt     = r_rem;
    w_err_nxt     = r_err;
    w_timeout_nxt = r_timeout;
    case (r_state)
      S_IDLE: if (job_valid) begin
        w_accept      = 1'b1;
        w_err_nxt     = ERR_OK;
        w_timeout_nxt = 1'b0;
        w_cnt_nxt     = '0;
        w_addr_nxt    = job_addr;
        w_rem_nxt     = job_count;
        if (job_op == OP_RDID) begin
          w_issue = 1'b1; w_issue_cmd = CMD_RDID; w_state_nxt = S_RDID;
        end else if (job_count == '0) begin
          w_err_nxt = ERR_COUNT; w_state_nxt = S_DONE;
        end else if (w_range_bad) begin
          w_err_nxt = ERR_RANGE; w_state_nxt = S_DONE;
        end else if (job_op == OP_READ) begin
          w_issue = 1'b1; w_issue_cmd = CMD_READ; w_state_nxt = S_EXEC;
        end else begin
          w_issue = 1'b1; w_issue_cmd = CMD_WREN; w_state_nxt = S_WREN;
        end
      end
      S_RDID: if (w_active && Done_Sig) begin
        w_clear = 1'b1; w_id_load = 1'b1; w_state_nxt = S_DONE;
      end
      S_WREN: if (w_active && Done_Sig) begin
        w_clear = 1'b1; w_cnt_nxt = '0; w_state_nxt = S_GAP;
      end
      S_GAP: begin
        // The gap itself supplies the idle separation, so EXEC issues on the way out.
        if (r_cnt == 16'(GAP_CYCLES - 1)) begin
          w_issue = 1'b1; w_issue_cmd = exec_cmd(r_op); w_state_nxt = S_EXEC;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_EXEC: if (w_active && Done_Sig) begin
        w_clear   = 1'b1;
        w_cnt_nxt = '0;
        if (r_op == OP_READ) w_state_nxt = S_NEXT;
        else                 w_state_nxt = S_POLL;
      end
      S_POLL, S_POLL2: begin
        if (!w_active) begin
          w_issue = 1'b1; w_issue_cmd = CMD_RDSR;
        end else if (Done_Sig) begin
          w_clear = 1'b1;
          if (!mydata_o[0]) begin
            w_cnt_nxt = '0;
            if (r_state == S_POLL) w_state_nxt = S_WRDI;
            else                   w_state_nxt = S_NEXT;
          end else if (w_cnt_inc == 16'(POLL_MAX)) begin
            w_timeout_nxt = 1'b1; w_cnt_nxt = '0; w_state_nxt = S_WRDI;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_WRDI: begin
        if (!w_active) begin
          w_issue = 1'b1; w_issue_cmd = CMD_WRDI;
        end else if (Done_Sig) begin
          w_clear   = 1'b1;
          w_cnt_nxt = '0;
          if (r_timeout) begin
            w_err_nxt = ERR_TIMEOUT; w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_POLL2;
          end
        end
      end
      S_NEXT: begin
        w_rem_nxt  = r_rem - CNT_W'(1);
        w_addr_nxt = r_addr + w_stride;
        if (w_rem_nxt == '0) begin
          w_state_nxt = S_DONE;
        end else if (job_abort) begin
          w_err_nxt = ERR_ABORT; w_state_nxt = S_DONE;
        end else if (r_op == OP_READ) begin
          w_issue = 1'b1; w_issue_cmd = CMD_READ; w_state_nxt = S_EXEC;
        end else begin
          w_issue = 1'b1; w_issue_cmd = CMD_WREN; w_state_nxt = S_WREN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_op         <= OP_RDID;
      r_addr       <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
      r_err        <= ERR_OK;
      r_cmd        <= CMD_NONE;
      r_flash_cmd  <= '0;
      r_flash_addr <= '0;
      r_id_byte    <= '0;
    end else begin
      r_addr    <= w_addr_nxt;
      r_rem     <= w_rem_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_err     <= w_err_nxt;
      if (w_accept)  r_op      <= op_e'(job_op);
      if (w_id_load) r_id_byte <= mydata_o;
      if (w_issue) begin
        r_cmd        <= w_issue_cmd;
        r_flash_cmd  <= opcode_of(w_issue_cmd);
        r_flash_addr <= w_exec_issue ? w_addr_nxt : '0;
      end else if (w_clear) begin
        r_cmd       <= CMD_NONE;
        r_flash_cmd <= '0;
      end
    end
  end

  assign job_ready  = (r_state == S_IDLE);
  assign job_done   = (r_state == S_DONE);
  assign err_code   = r_err;
  assign cmd_type   = r_cmd;
  assign flash_cmd  = r_flash_cmd;
  assign flash_addr = r_flash_addr;
  assign id_byte    = r_id_byte;

endmodule

// File: tb/tb_flash_job_sequencer.sv
// Bench for flash_job_sequencer: table of jobs against a command-engine model, with a
// scoreboard of expected engine commands plus hand-written reset and spurious-Done cases.
module tb_flash_job_sequencer;

  localparam int TB_GAP      = 100;
  localparam int TB_POLL_MAX = 4;
  localparam int BUDGET      = 3000;

  logic        CLK, RST;
  logic        job_valid, job_ready, job_abort, job_done, Done_Sig;
  logic [1:0]  job_op;
  logic [23:0] job_addr, flash_addr;
  logic [7:0]  job_count, flash_cmd, mydata_o, id_byte;
  logic [2:0]  err_code;
  logic [3:0]  cmd_type;

  flash_job_sequencer #(.POLL_MAX(TB_POLL_MAX)) dut (
    .CLK(CLK), .RST(RST), .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op),
    .job_addr(job_addr), .job_count(job_count), .job_abort(job_abort), .job_done(job_done),
    .err_code(err_code), .cmd_type(cmd_type), .flash_cmd(flash_cmd), .flash_addr(flash_addr),
    .Done_Sig(Done_Sig), .mydata_o(mydata_o), .id_byte(id_byte)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [23:0] addr;
    logic [7:0]  cnt;
    int          busy;
    bit          stuck;
    int          abort_after;
    bit          poke;
    bit          chk_id;
    int          max_lat;
    logic [2:0]  exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]  ct;
    logic [7:0]  fc;
    logic [23:0] fa;
    bit          chk_fa;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cfg_busy = 0;
  bit   cfg_stuck = 0;
  int   abort_after = 0;
  bit   spurious_req = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic [3:0] ct, input logic [7:0] fc, input logic [23:0] fa,
                          input bit chk);
    exp_t e;
    e.ct = ct; e.fc = fc; e.fa = fa; e.chk_fa = chk;
    exp_q.push_back(e);
  endtask

  // Expected engine command stream for one job, derived from the job description alone.
  task automatic gen_expected(input vec_t v);
    longint      stride;
    int          units;
    logic [23:0] a;
    stride = (v.op == 2'b01) ? 64'd4096 : 64'd256;
    if (v.op == 2'b00) begin
      push_cmd(4'h8, 8'h90, 24'h0, 1'b1);
      return;
    end
    if (v.cnt == 0) return;
    if (longint'(v.addr) + longint'(v.cnt) * stride > 64'h100_0000) return;
    units = (v.abort_after != 0) ? v.abort_after : int'(v.cnt);
    for (int u = 0; u < units; u++) begin
      a = v.addr + 24'(longint'(u) * stride);
      if (v.op == 2'b11) begin
        push_cmd(4'hE, 8'h03, a, 1'b1);
      end else begin
        push_cmd(4'h9, 8'h06, 24'h0, 1'b0);
        if (v.op == 2'b01) push_cmd(4'hA, 8'h20, a, 1'b1);
        else               push_cmd(4'hD, 8'h02, a, 1'b1);
        if (v.stuck) begin
          for (int p = 0; p < TB_POLL_MAX; p++) push_cmd(4'hB, 8'h05, 24'h0, 1'b0);
          push_cmd(4'hC, 8'h04, 24'h0, 1'b0);
          return;
        end
        for (int p = 0; p <= v.busy; p++) push_cmd(4'hB, 8'h05, 24'h0, 1'b0);
        push_cmd(4'hC, 8'h04, 24'h0, 1'b0);
        push_cmd(4'hB, 8'h05, 24'h0, 1'b0);
      end
    end
  endtask

  // Engine model and command monitor share one process so their view of each cycle is ordered.
  initial begin : engine_monitor
    int          lat, busy_left, idle_run, read_issued;
    logic [3:0]  prev_ct;
    logic [7:0]  prev_fc;
    logic [23:0] prev_fa;
    bit          prev_done;
    exp_t        e;
    Done_Sig = 1'b0; mydata_o = 8'h00; job_abort = 1'b0;
    lat = 0; busy_left = 0; idle_run = 0; read_issued = 0;
    prev_ct = '0; prev_fc = '0; prev_fa = '0; prev_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        Done_Sig = 1'b0; prev_ct = '0; prev_done = 1'b0; idle_run = 0; lat = 0;
        continue;
      end
      if (prev_done) check("clear_on_done", {cmd_type, flash_cmd}, 12'h0);
      if (cmd_type != 4'h0) begin
        if (prev_ct == 4'h0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_cmd", {cmd_type, flash_cmd}, 12'h0);
          end else begin
            e = exp_q.pop_front();
            check("cmd_type", cmd_type, e.ct);
            check("flash_cmd", flash_cmd, e.fc);
            if (e.chk_fa) check("flash_addr", flash_addr, e.fa);
          end
          if (cmd_type == 4'hA || cmd_type == 4'hD) begin
            check("gap_len_ok", (idle_run >= TB_GAP) ? 1 : 0, 1);
            busy_left = cfg_stuck ? 32'h7fff_ffff : cfg_busy;
          end
          if (cmd_type == 4'hE) read_issued++;
        end else begin
          check("cmd_hold", {cmd_type, flash_cmd, flash_addr}, {prev_ct, prev_fc, prev_fa});
        end
        idle_run = 0;
      end else begin
        idle_run++;
      end
      prev_ct = cmd_type; prev_fc = flash_cmd; prev_fa = flash_addr;
      if (job_ready) read_issued = 0;
      job_abort = (abort_after != 0) && (read_issued >= abort_after);
      Done_Sig = 1'b0;
      if (cmd_type != 4'h0) begin
        if (lat == 0) begin
          case (cmd_type)
            4'h8: mydata_o = 8'hEF;
            4'hB: begin
              if (busy_left > 0) begin mydata_o = 8'h03; busy_left--; end
              else mydata_o = 8'h00;
            end
            default: mydata_o = 8'hA5;
          endcase
          Done_Sig = 1'b1;
          lat = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end else begin
        lat = $urandom_range(0, 3);
        if (spurious_req) begin Done_Sig = 1'b1; mydata_o = 8'h5A; end
      end
      prev_done = Done_Sig && (cmd_type != 4'h0);
    end
  end

  task automatic run_job(input vec_t v);
    int cyc;
    bit seen;
    cfg_busy = v.busy; cfg_stuck = v.stuck; abort_after = v.abort_after;
    gen_expected(v);
    @(negedge CLK);
    check({v.name, "_ready_before"}, job_ready, 1'b1);
    job_valid = 1'b1; job_op = v.op; job_addr = v.addr; job_count = v.cnt;
    @(negedge CLK);
    job_valid = 1'b0;
    if (v.poke) begin job_op = 2'b00; job_count = 8'd1; end
    check({v.name, "_ready_drop"}, job_ready, 1'b0);
    cyc = 1; seen = 0;
    while (!seen && cyc < BUDGET) begin
      if (job_done) seen = 1;
      else begin
        job_valid = v.poke && (cyc >= 2) && (cyc <= 4);
        @(negedge CLK);
        cyc++;
      end
    end
    job_valid = 1'b0;
    check({v.name, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      check({v.name, "_err"}, err_code, v.exp_err);
      check({v.name, "_cmds_left"}, exp_q.size(), 0);
      if (v.max_lat != 0) check({v.name, "_fast_done"}, (cyc <= v.max_lat) ? 1 : 0, 1);
      if (v.chk_id) check({v.name, "_id_byte"}, id_byte, 8'hEF);
      @(negedge CLK);
      check({v.name, "_done_pulse"}, job_done, 1'b0);
      check({v.name, "_err_hold"}, err_code, v.exp_err);
      check({v.name, "_ready_after"}, job_ready, 1'b1);
    end
    exp_q.delete();
    abort_after = 0;
    @(negedge CLK);
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] op, input logic [23:0] a,
                              input logic [7:0] c, input int busy, input bit stuck,
                              input int ab, input bit poke, input bit chk_id,
                              input int max_lat, input logic [2:0] err);
    vec_t v;
    v.name = n; v.op = op; v.addr = a; v.cnt = c; v.busy = busy; v.stuck = stuck;
    v.abort_after = ab; v.poke = poke; v.chk_id = chk_id; v.max_lat = max_lat; v.exp_err = err;
    return v;
  endfunction

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[13];
    int   cyc;
    vecs[0]  = mk("rdid",         2'b00, 24'h123456, 8'd0, 0, 0, 0, 0, 1, 0, 3'b000);
    vecs[1]  = mk("erase2",       2'b01, 24'h000000, 8'd2, 3, 0, 0, 0, 0, 0, 3'b000);
    vecs[2]  = mk("prog3",        2'b10, 24'h000100, 8'd3, 1, 0, 0, 0, 0, 0, 3'b000);
    vecs[3]  = mk("read_cnt0",    2'b11, 24'h000000, 8'd0, 0, 0, 0, 0, 0, 2, 3'b010);
    vecs[4]  = mk("read_range",   2'b11, 24'hFFFF00, 8'd2, 0, 0, 0, 0, 0, 2, 3'b011);
    vecs[5]  = mk("erase_stuck",  2'b01, 24'h005000, 8'd1, 0, 1, 0, 0, 0, 0, 3'b001);
    vecs[6]  = mk("read_abort",   2'b11, 24'h040000, 8'd5, 0, 0, 2, 0, 0, 0, 3'b100);
    vecs[7]  = mk("read_lastpg",  2'b11, 24'hFFFF00, 8'd1, 0, 0, 0, 0, 0, 0, 3'b000);
    vecs[8]  = mk("erase_lastsec",2'b01, 24'hFFF000, 8'd1, 0, 0, 0, 0, 0, 0, 3'b000);
    vecs[9]  = mk("erase_range",  2'b01, 24'hFFF000, 8'd2, 0, 0, 0, 0, 0, 2, 3'b011);
    vecs[10] = mk("prog_cnt0",    2'b10, 24'h000000, 8'd0, 0, 0, 0, 0, 0, 2, 3'b010);
    vecs[11] = mk("erase_poke",   2'b01, 24'h002000, 8'd1, 2, 0, 0, 1, 0, 0, 3'b000);
    vecs[12] = mk("read3",        2'b11, 24'h000200, 8'd3, 0, 0, 0, 0, 0, 0, 3'b000);

    RST = 1'b1; job_valid = 1'b0; job_op = 2'b00; job_addr = '0; job_count = '0;
    repeat (3) @(negedge CLK);
    check("rst_ready", job_ready, 1'b1);
    check("rst_done", job_done, 1'b0);
    check("rst_err", err_code, 3'b000);
    check("rst_outs", {cmd_type, flash_cmd, flash_addr, id_byte}, 44'h0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 13; i++) run_job(vecs[i]);

    // Done_Sig while idle must not disturb anything.
    @(negedge CLK); #1 spurious_req = 1'b1;
    @(negedge CLK); #1 spurious_req = 1'b0;
    repeat (3) @(negedge CLK);
    check("spurious_id", id_byte, 8'hEF);
    check("spurious_idle", {job_ready, job_done, cmd_type}, {1'b1, 1'b0, 4'h0});

    // Reset in the middle of a READ command abandons the job at once.
    push_cmd(4'hE, 8'h03, 24'h003000, 1'b1);
    @(negedge CLK);
    job_valid = 1'b1; job_op = 2'b11; job_addr = 24'h003000; job_count = 8'd3;
    @(negedge CLK);
    job_valid = 1'b0;
    cyc = 0;
    while (cmd_type != 4'hE && cyc < 50) begin @(negedge CLK); cyc++; end
    check("rst_mid_exec_seen", cmd_type, 4'hE);
    #1 RST = 1'b1;
    #1;
    check("rst_mid_cmd", {cmd_type, flash_cmd}, 12'h0);
    check("rst_mid_ready", job_ready, 1'b1);
    @(negedge CLK); #1 RST = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge CLK);
    check("post_rst_idle", {job_ready, cmd_type}, {1'b1, 4'h0});
    check("post_rst_id", id_byte, 8'h00);

    run_job(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
